// File: rtl/mat_print_pkg.sv
// -----------------------------------------------------------------------------
// mat_print_pkg
// Shared definitions for the matrix stream printer: the ASCII bytes it emits,
// the formatter FSM state encoding and the 3-character field type.
// -----------------------------------------------------------------------------
package mat_print_pkg;

  localparam logic [7:0] ASC_SPACE = 8'h20;
  localparam logic [7:0] ASC_CR    = 8'h0D;
  localparam logic [7:0] ASC_LF    = 8'h0A;
  localparam logic [7:0] ASC_ZERO  = 8'h30;
  localparam logic [7:0] ASC_E     = 8'h45;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EMIT = 2'd1,
    S_ERR  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  // One rendered element: hundreds, tens and ones characters, already ASCII.
  typedef struct packed {
    logic [7:0] hund;
    logic [7:0] tens;
    logic [7:0] ones;
  } field_t;

endpackage

// File: rtl/mat_elem_fifo.sv
// -----------------------------------------------------------------------------
// mat_elem_fifo
// Synchronous FIFO holding {last, elem} entries between the element stream and
// the text formatter. Read data is combinational from the head entry, so it is
// valid in the same cycle as the pop. Simultaneous push and pop are supported,
// including a push into a full FIFO that is popped in the same cycle.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   push, wdata      write strobe and entry
//   pop, rdata       read strobe and head entry
//   full, empty      status flags
//   count            number of stored entries (0..DEPTH)
// -----------------------------------------------------------------------------
module mat_elem_fifo #(
  parameter int WIDTH     = 9,
  parameter int DEPTH     = 32,
  parameter int ADDR_BITS = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [WIDTH-1:0]     wdata,
  input  logic                 pop,
  output logic [WIDTH-1:0]     rdata,
  output logic                 full,
  output logic                 empty,
  output logic [ADDR_BITS:0]   count
);

  logic [WIDTH-1:0]   mem [DEPTH];
  logic [ADDR_BITS-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_BITS:0]   count_q, count_d;
  logic                 do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (ADDR_BITS+1)'(DEPTH));
  assign count   = count_q;
  assign rdata   = mem[rd_ptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: storage has no reset; entries are only read after being written, so
  // clearing the pointers and count is enough and the array stays plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mat_stream_printer.sv
// -----------------------------------------------------------------------------
// mat_stream_printer
// Renders the transposer's element stream as ASCII text, one matrix row per
// line, each element as a 3-character right-justified decimal field followed
// by a space, or by CR LF at the end of a row. An error frame prints "E\r\n".
// Elements are buffered in a FIFO because the producer cannot be stalled.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   in_valid, in_col,      element strobe, column index, value and column
//   in_elem, in_cols         count of the transposed matrix
//   in_frame_end, in_error end-of-matrix pulse and its slot-error flag
//   tx_valid, tx_data,     byte stream towards the UART transmitter
//   tx_ready
//   busy                   work queued, in flight or frame end pending
//   print_done             one-cycle pulse after the frame text is accepted
//   overflow               sticky element-dropped flag, cleared after a frame
// -----------------------------------------------------------------------------
module mat_stream_printer
  import mat_print_pkg::*;
#(
  parameter int MAX_DIM    = 5,
  parameter int DIM_BITS   = (MAX_DIM <= 1) ? 1 : $clog2(MAX_DIM),
  parameter int FIFO_DEPTH = 32,
  parameter int ADDR_BITS  = $clog2(FIFO_DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [DIM_BITS-1:0] in_col,
  input  logic [7:0]          in_elem,
  input  logic [3:0]          in_cols,
  input  logic                in_frame_end,
  input  logic                in_error,
  output logic                tx_valid,
  output logic [7:0]          tx_data,
  input  logic                tx_ready,
  output logic                busy,
  output logic                print_done,
  output logic                overflow
);

  if (FIFO_DEPTH < MAX_DIM * MAX_DIM || (1 << ADDR_BITS) != FIFO_DEPTH) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of 2 holding a full MAX_DIM x MAX_DIM matrix");
  end

  // ---------------------------------------------------------------------------
  // Digit conversion by compare/subtract: hundreds from the >=200 / >=100
  // tests, tens from a descending chain, the remainder is the ones digit.
  // Leading zeros are blanked so the field is right-justified.
  // ---------------------------------------------------------------------------
  // NOTE: blocking assignments are correct here: a function body is
  // combinational and each temporary must see the value just computed.
  function automatic field_t to_field(input logic [7:0] v);
    field_t     f;
    logic [7:0] r;
    logic [3:0] h;
    logic [3:0] t;
    r = v;
    h = 4'd0;
    t = 4'd0;
    if (r >= 8'd200) begin
      h = 4'd2;
      r = r - 8'd200;
    end else if (r >= 8'd100) begin
      h = 4'd1;
      r = r - 8'd100;
    end
    for (int k = 9; k >= 1; k--) begin
      if (t == 4'd0 && r >= 8'(k * 10)) begin
        t = 4'(k);
        r = r - 8'(k * 10);
      end
    end
    f.hund = (v < 8'd100) ? ASC_SPACE : ASC_ZERO + {4'd0, h};
    f.tens = (v < 8'd10)  ? ASC_SPACE : ASC_ZERO + {4'd0, t};
    f.ones = ASC_ZERO + r;
    return f;
  endfunction

  // Character idx of an element: three digits, then separator or CR, then LF.
  function automatic logic [7:0] elem_char(input field_t f, input logic last,
                                           input logic [2:0] idx);
    case (idx)
      3'd0:    return f.hund;
      3'd1:    return f.tens;
      3'd2:    return f.ones;
      3'd3:    return last ? ASC_CR : ASC_SPACE;
      default: return ASC_LF;
    endcase
  endfunction

  function automatic logic [7:0] err_char(input logic [2:0] idx);
    case (idx)
      3'd0:    return ASC_E;
      3'd1:    return ASC_CR;
      default: return ASC_LF;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Element FIFO
  // ---------------------------------------------------------------------------
  state_e             state_q;
  logic               fifo_full, fifo_empty, fifo_pop, push_ok, in_last;
  logic [8:0]         fifo_rdata;
  logic [ADDR_BITS:0] fifo_count;
  field_t             pop_field;

  // A column count of zero never matches, so such elements never end a row.
  assign in_last  = (in_cols != 4'd0) && (4'(in_col) == in_cols - 4'd1);
  assign fifo_pop = (state_q == S_IDLE) && !fifo_empty;
  // A full FIFO still accepts when the formatter frees a slot this cycle.
  assign push_ok  = in_valid && (!fifo_full || fifo_pop);
  assign pop_field = to_field(fifo_rdata[7:0]);

  mat_elem_fifo #(
    .WIDTH     (9),
    .DEPTH     (FIFO_DEPTH),
    .ADDR_BITS (ADDR_BITS)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_ok),
    .wdata ({in_last, in_elem}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // ---------------------------------------------------------------------------
  // Formatter FSM with registered outputs
  // ---------------------------------------------------------------------------
  field_t     field_q;
  logic       last_q;
  logic [2:0] char_idx_q;
  logic       tx_valid_q;
  logic [7:0] tx_data_q;
  logic       print_done_q;
  logic       end_pending_q;
  logic       err_pending_q;
  logic       overflow_q;
  logic       handshake;

  assign handshake = tx_valid_q && tx_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      field_q       <= '0;
      last_q        <= 1'b0;
      char_idx_q    <= 3'd0;
      tx_valid_q    <= 1'b0;
      tx_data_q     <= 8'h00;
      print_done_q  <= 1'b0;
      end_pending_q <= 1'b0;
      err_pending_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      print_done_q <= 1'b0;

      // Frame-end bookkeeping; a new pulse wins over the clear in S_DONE,
      // and a repeat pulse while pending ORs its error flag in.
      if (in_frame_end) begin
        end_pending_q <= 1'b1;
        err_pending_q <= ((end_pending_q && state_q != S_DONE) ? err_pending_q : 1'b0)
                         | in_error;
      end else if (state_q == S_DONE) begin
        end_pending_q <= 1'b0;
        err_pending_q <= 1'b0;
      end

      // Overflow stays visible through the print_done cycle.
      if (in_valid && !push_ok) begin
        overflow_q <= 1'b1;
      end else if (state_q == S_DONE) begin
        overflow_q <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          // The FIFO is served first so print_done always trails the last LF.
          if (!fifo_empty) begin
            field_q    <= pop_field;
            last_q     <= fifo_rdata[8];
            char_idx_q <= 3'd0;
            tx_data_q  <= pop_field.hund;
            tx_valid_q <= 1'b1;
            state_q    <= S_EMIT;
          end else if (end_pending_q && err_pending_q) begin
            char_idx_q <= 3'd0;
            tx_data_q  <= ASC_E;
            tx_valid_q <= 1'b1;
            state_q    <= S_ERR;
          end else if (end_pending_q) begin
            print_done_q <= 1'b1;
            state_q      <= S_DONE;
          end
        end

        S_EMIT: begin
          if (handshake) begin
            if (char_idx_q == (last_q ? 3'd4 : 3'd3)) begin
              tx_valid_q <= 1'b0;
              state_q    <= S_IDLE;
            end else begin
              char_idx_q <= char_idx_q + 3'd1;
              tx_data_q  <= elem_char(field_q, last_q, char_idx_q + 3'd1);
            end
          end
        end

        S_ERR: begin
          if (handshake) begin
            if (char_idx_q == 3'd2) begin
              tx_valid_q   <= 1'b0;
              print_done_q <= 1'b1;
              state_q      <= S_DONE;
            end else begin
              char_idx_q <= char_idx_q + 3'd1;
              tx_data_q  <= err_char(char_idx_q + 3'd1);
            end
          end
        end

        S_DONE: begin
          state_q <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign tx_valid   = tx_valid_q;
  assign tx_data    = tx_data_q;
  assign print_done = print_done_q;
  assign overflow   = overflow_q;
  assign busy       = (fifo_count != '0) || (state_q != S_IDLE) || end_pending_q;

endmodule
